layer_sr_ctrl: RTL and testbench
================================

# layer_sr_ctrl

Sequencing controller for the convolution layer's window shift-register chain (parallel-out window rows plus RAM row-delay lines). It accepts a raster-ordered 8-bit pixel stream through a valid/ready handshake and gates each shift of the chain. It tracks row and column position within the frame and flags the cycles in which the parallel window holds a complete, in-bounds WIN_W×WIN_H patch. Downstream MAC logic consumes windows under its own ready, which back-pressures the pixel source.

## Interface
- IMG_WIDTH, 28: pixels per image row; the chain's RAM delay depth must equal IMG_WIDTH-WIN_W.
- IMG_HEIGHT, 28: rows per frame.
- WIN_W, 3: window width, equal to the chain's parallel-row depth.
- WIN_H, 3: window height, equal to the chain's row count.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a frame; sampled only in IDLE.
- pixel_in  in  8  incoming pixel.
- in_valid  in  1  pixel_in is valid.
- in_ready  out  1  controller accepts pixel this cycle.
- sr_shift_in  out  8  data to the chain input; equals pixel_in combinationally.
- sr_shift_en  out  1  shift enable for the whole chain; equals in_valid & in_ready.
- window_valid  out  1  the chain's window output is a complete, in-bounds patch.
- out_ready  in  1  downstream consumes the window this cycle.
- win_row  out  $clog2(IMG_HEIGHT)  bottom-row index of the current window.
- win_col  out  $clog2(IMG_WIDTH)  right-column index of the current window.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse when the frame completes.

## Operation
- States:
  - IDLE: start → RUN; row and col are cleared.
  - RUN: accepting pixels.
  - DRAIN: last pixel has been accepted and the final window is awaiting consumption.
  - DONE: one cycle, with frame_done=1 → IDLE.
- in_ready = (state==RUN) && (!window_valid || out_ready).
- The accept event is in_valid & in_ready. On accept:
  - the chain shifts;
  - col increments and wraps to 0 at IMG_WIDTH-1, at which point row increments.
- On accept of pixel (r,c), window_valid is set next cycle iff r≥WIN_H-1 and c≥WIN_W-1. win_row/win_col load (r,c) at the same time.
- On accept of pixel (r,c) outside those bounds, window_valid is cleared next cycle. This covers the left-edge wrap windows, which are never flagged.
- With no accept, window_valid clears on out_ready. Otherwise window_valid holds, and win_row/win_col and the chain are frozen.
- Simultaneous out_ready and accept: the current window is consumed, and the next window status comes from the new pixel with no bubble.
- Accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) → DRAIN, with row and col returning to 0.
- DRAIN → DONE when window_valid is 0 or out_ready is 1.
- start outside IDLE is ignored. in_valid outside RUN is ignored, and no shift occurs.
- Reset outputs: state IDLE; in_ready, window_valid, busy, frame_done, win_row, win_col, row, col all 0.
- Reset mid-frame aborts the frame with no frame_done. The chain shares the same reset, so it is cleared too.

## Timing
- Pixel-to-window latency: window_valid rises 1 cycle after the accept that completes it.
- Throughput: 1 pixel/cycle when in_valid and out_ready are held high.
- Frame windows: (IMG_WIDTH-WIN_W+1)·(IMG_HEIGHT-WIN_H+1).
- frame_done fires 1 cycle after the final window is consumed, or 2 cycles after the last accept if out_ready is high throughout.
- All outputs are registered except in_ready, sr_shift_in and sr_shift_en.

## Structure
- Package layer_sr_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - a localparam function checking that WIN_W≤IMG_WIDTH and WIN_H≤IMG_HEIGHT.
- One sub-module, raster_counter: a parameterized col/row counter with increment enable, wrap, and a last-pixel flag.
- FSM and window-valid logic live in layer_sr_ctrl.

## Test plan
- Fill with IMG 5×4, WIN 3×3, in_valid=out_ready=1: window_valid first rises the cycle after the 13th accept (r=2,c=2), with win_row=2, win_col=2.
- Full frame, same setup: exactly 6 window_valid cycles at (2,2),(2,3),(2,4),(3,2),(3,3),(3,4); frame_done 2 cycles after the 20th accept; back to IDLE.
- Backpressure: out_ready=0 for 4 cycles at the first window → in_ready=0, sr_shift_en=0, and window/coords held; on release the window is consumed and the next pixel is accepted the same cycle.
- Source gaps: in_valid toggling 1,0,1,0 → no shift on idle cycles and the window count is still 6.
- Reset asserted at accept #9 → all outputs 0 asynchronously and no frame_done; a new start runs a clean frame with 6 windows.
- start pulsed during RUN and in_valid=1 in IDLE → both ignored; counters unchanged.

Source files
------------

// File: rtl/layer_sr_pkg.sv
// Shared types and elaboration-time helpers for the convolution window controller.
package layer_sr_pkg;

   // Frame sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // True when the window fits inside the image.
   function automatic bit geometry_ok(input int img_w, input int img_h,
                                      input int win_w, input int win_h);
      return (win_w >= 1) && (win_h >= 1) && (win_w <= img_w) && (win_h <= img_h);
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: column runs fastest, row advances on column wrap,
// both wrap to zero after the last pixel of the frame.
module raster_counter #(
   parameter int WIDTH  = 28,
   parameter int HEIGHT = 28,
   parameter int CW     = $clog2(WIDTH),
   parameter int RW     = $clog2(HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

   assign last = (col == COL_MAX) && (row == ROW_MAX);

   // Advance position on each increment; clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (inc) begin
         if (col == COL_MAX) begin
            col <= '0;
            if (row == ROW_MAX) begin
               row <= '0;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/layer_sr_ctrl.sv
// Sequencing controller for the window shift-register chain: gates each
// shift on the pixel handshake, tracks raster position and flags cycles in
// which the parallel window holds a complete, in-bounds patch.
module layer_sr_ctrl
   import layer_sr_pkg::*;
#(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int WIN_W      = 3,
   parameter int WIN_H      = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [7:0]                    pixel_in,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [7:0]                    sr_shift_in,
   output logic                          sr_shift_en,
   output logic                          window_valid,
   input  logic                          out_ready,
   output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
   output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int CW = $clog2(IMG_WIDTH);

   // An impossible geometry never accepts pixels, so the frame simply stalls.
   localparam bit GEOM_OK = geometry_ok(IMG_WIDTH, IMG_HEIGHT, WIN_W, WIN_H);

   localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_H - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(WIN_W - 1);

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last_pixel;
   logic          accept;
   logic          count_clr;
   logic          in_bounds;

   // A held window blocks new pixels unless it is being consumed this cycle.
   assign in_ready    = GEOM_OK && (state == RUN) && (!window_valid || out_ready);
   assign accept      = in_valid && in_ready;
   assign sr_shift_en = accept;
   assign sr_shift_in = pixel_in;
   assign count_clr   = (state == IDLE);
   assign in_bounds   = (row >= ROW_FIRST) && (col >= COL_FIRST);

   raster_counter #(
      .WIDTH  (IMG_WIDTH),
      .HEIGHT (IMG_HEIGHT),
      .CW     (CW),
      .RW     (RW)
   ) u_raster (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (count_clr),
      .inc   (accept),
      .col   (col),
      .row   (row),
      .last  (last_pixel)
   );

   // Frame FSM with registered window flag, coordinates and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         window_valid <= 1'b0;
         win_row      <= '0;
         win_col      <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  // The new pixel decides the window status; left-edge wrap
                  // windows fall outside the bounds and are never flagged.
                  window_valid <= in_bounds;
                  win_row      <= row;
                  win_col      <= col;
                  if (last_pixel) begin
                     state <= DRAIN;
                  end
               end else if (out_ready) begin
                  window_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (!window_valid || out_ready) begin
                  window_valid <= 1'b0;
                  state        <= DONE;
                  busy         <= 1'b0;
                  frame_done   <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_sr_ctrl.sv
// Randomized bench for layer_sr_ctrl on a 5x4 image with a 3x3 window,
// checked against a pixel-count based reference model.
module tb_layer_sr_ctrl;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int WW = 3;
   localparam int WH = 3;
   localparam int BUDGET = 400;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] pixel_in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sr_shift_in;
   logic       sr_shift_en;
   logic       window_valid;
   logic       out_ready;
   logic [1:0] win_row;
   logic [2:0] win_col;
   logic       busy;
   logic       frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   int phase;
   int count;
   int m_wv, m_wr, m_wc, m_busy, m_fd;
   int exp_r[$];
   int exp_c[$];

   always #5 clk = ~clk;

   layer_sr_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .WIN_W      (WW),
      .WIN_H      (WH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .pixel_in     (pixel_in),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sr_shift_in  (sr_shift_in),
      .sr_shift_en  (sr_shift_en),
      .window_valid (window_valid),
      .out_ready    (out_ready),
      .win_row      (win_row),
      .win_col      (win_col),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      phase  = P_IDLE;
      count  = 0;
      m_wv   = 0;
      m_wr   = 0;
      m_wc   = 0;
      m_busy = 0;
      m_fd   = 0;
   endtask

   task automatic check_regs(input string where);
      check_eq({where, ".window_valid"}, window_valid, m_wv);
      check_eq({where, ".win_row"}, win_row, m_wr);
      check_eq({where, ".win_col"}, win_col, m_wc);
      check_eq({where, ".busy"}, busy, m_busy);
      check_eq({where, ".frame_done"}, frame_done, m_fd);
   endtask

   // In IDLE, valid pixels and the handshake must be ignored.
   task automatic idle_poke();
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pixel_in = 8'($urandom);
         #1;
         check_eq("idle.in_ready", in_ready, 0);
         check_eq("idle.sr_shift_en", sr_shift_en, 0);
         @(posedge clk);
         #1;
         check_regs("idle");
      end
      in_valid = 1'b0;
      $display("idle poke: 3 cycles with in_valid=1, no accepts");
   endtask

   // vmode: 0 always valid, 1 alternating, 2 random.
   // rmode: 0 always ready, 1 four-cycle stall at first window, 2 random.
   // abort_at: nonzero resets the DUT just before that accept.
   task automatic run_frame(input int vmode, input int rmode, input int abort_at);
      int  consumed, stall_left, fd_seen, acc;
      int  first_wv_cyc, acc_first_cyc, last_acc_cyc, fd_cyc;
      int  exp_ready, r, c, er, ec;
      bit  finished;
      consumed = 0; stall_left = 4; fd_seen = 0; finished = 0;
      first_wv_cyc = -1; acc_first_cyc = -1; last_acc_cyc = -1; fd_cyc = -1;
      exp_r.delete();
      exp_c.delete();
      for (int rr = WH - 1; rr < H; rr++)
         for (int cc = WW - 1; cc < W; cc++) begin
            exp_r.push_back(rr);
            exp_c.push_back(cc);
         end

      start = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      phase = P_RUN;
      m_busy = 1;
      count = 0;

      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         check_regs("frame");
         if (window_valid === 1'b1 && first_wv_cyc < 0) begin
            first_wv_cyc = cyc;
            if (vmode == 0 && rmode == 0) begin
               check_eq("first_window.latency", first_wv_cyc - acc_first_cyc, 1);
               check_eq("first_window.row", win_row, WH - 1);
               check_eq("first_window.col", win_col, WW - 1);
            end
         end
         if (frame_done === 1'b1) begin
            fd_seen++;
            fd_cyc = cyc;
         end
         if (phase == P_IDLE) begin
            finished = 1;
            break;
         end

         // Drive inputs for this cycle.
         pixel_in = 8'($urandom);
         case (vmode)
            0: in_valid = 1'b1;
            1: in_valid = (cyc % 2 == 0);
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         case (rmode)
            1: begin
               if (m_wv != 0 && stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else begin
                  out_ready = 1'b1;
               end
            end
            2: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
         endcase
         start = (rmode == 2 && phase == P_RUN) ? ($urandom_range(0, 3) == 0) : 1'b0;

         #1;
         exp_ready = (phase == P_RUN) && (m_wv == 0 || out_ready);
         check_eq("in_ready", in_ready, exp_ready);
         check_eq("sr_shift_en", sr_shift_en, exp_ready && in_valid);
         check_eq("sr_shift_in", sr_shift_in, pixel_in);

         if (abort_at != 0 && exp_ready != 0 && in_valid && count == abort_at - 1) begin
            rst_n = 1'b0;
            #1;
            check_eq("abort.in_ready", in_ready, 0);
            check_eq("abort.sr_shift_en", sr_shift_en, 0);
            check_eq("abort.window_valid", window_valid, 0);
            check_eq("abort.busy", busy, 0);
            check_eq("abort.frame_done", frame_done, 0);
            check_eq("abort.win_row", win_row, 0);
            check_eq("abort.win_col", win_col, 0);
            @(posedge clk);
            #1;
            check_eq("abort.frame_done_hold", frame_done, 0);
            @(negedge clk);
            rst_n = 1'b1;
            in_valid = 1'b0;
            start = 1'b0;
            @(posedge clk);
            #1;
            model_reset();
            check_regs("post_abort");
            $display("frame aborted by reset before accept %0d", abort_at);
            return;
         end

         // A held window consumed this cycle must be the next expected patch.
         if (m_wv != 0 && out_ready) begin
            er = (exp_r.size() > 0) ? exp_r.pop_front() : -1;
            ec = (exp_c.size() > 0) ? exp_c.pop_front() : -1;
            check_eq("consume.row", win_row, er);
            check_eq("consume.col", win_col, ec);
            consumed++;
            $display("window %0d consumed at row %0d col %0d", consumed, win_row, win_col);
         end

         @(posedge clk);
         acc = exp_ready && in_valid;
         m_fd = 0;
         case (phase)
            P_RUN: begin
               if (acc) begin
                  r = count / W;
                  c = count % W;
                  m_wv = (r >= WH - 1 && c >= WW - 1);
                  m_wr = r;
                  m_wc = c;
                  count++;
                  if (count == (WH - 1) * W + WW) acc_first_cyc = cyc;
                  if (count == W * H) begin
                     phase = P_DRAIN;
                     last_acc_cyc = cyc;
                  end
               end else if (out_ready) begin
                  m_wv = 0;
               end
            end
            P_DRAIN: begin
               if (m_wv == 0 || out_ready) begin
                  m_wv = 0;
                  phase = P_DONE;
                  m_busy = 0;
                  m_fd = 1;
               end
            end
            default: phase = P_IDLE;
         endcase
         #1;
      end

      start = 1'b0;
      in_valid = 1'b0;
      check_eq("frame.finished", finished, 1);
      check_eq("frame.windows", consumed, (W - WW + 1) * (H - WH + 1));
      check_eq("frame.done_pulses", fd_seen, 1);
      if (vmode == 0 && rmode == 0)
         check_eq("frame.done_latency", fd_cyc - last_acc_cyc, 2);
      $display("frame vmode=%0d rmode=%0d: %0d windows, frame_done pulses %0d",
               vmode, rmode, consumed, fd_seen);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pixel_in = 8'h00;
      in_valid = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_regs("reset");
      check_eq("reset.in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_regs("after_reset");

      idle_poke();
      run_frame(0, 0, 0);
      run_frame(0, 1, 0);
      run_frame(1, 0, 0);
      run_frame(0, 0, 9);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_eq("idle_after_abort.frame_done", frame_done, 0);
      end
      run_frame(0, 0, 0);
      idle_poke();
      for (int i = 0; i < 4; i++) run_frame(2, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
